eth_tx_frame_arbiter: RTL and testbench

Frame-granular round-robin arbiter sharing the single 8-bit MAC TX AXI-Stream input (the TX FIFO slave side) between PORTS requesters in the logic clock domain. Grant is held from the first beat to the accepted tlast, so frames never interleave. Frames longer than MAX_FRAME_LEN beats are truncated and marked bad; the TX FIFO bad-frame drop discards them. A per-port enable mask supports runtime port shutdown.

---
 rtl/eth_tx_arb_pkg.sv | 15 +
 rtl/eth_tx_frame_arbiter_rr_pick.sv | 30 +++
 rtl/eth_tx_frame_arbiter.sv | 147 ++++++++++++++
 tb/tb_eth_tx_frame_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_tx_arb_pkg.sv
// Shared types and helpers for the Ethernet TX frame arbiter.
package eth_tx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DROP = 2'd2
    } arb_state_e;

    // Index width that never collapses to zero bits.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/eth_tx_frame_arbiter_rr_pick.sv
// Combinational round-robin first-one finder: searches upward from rr_last+1 with wrap.
module rr_pick
    import eth_tx_arb_pkg::*;
#(
    parameter int PORTS = 4,
    parameter int IDX_W = idx_width(PORTS)
) (
    input  logic [PORTS-1:0] req,
    input  logic [IDX_W-1:0] rr_last,
    output logic [IDX_W-1:0] pick_idx,
    output logic             pick_vld
);

    logic [IDX_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        pick_idx = '0;
        pick_vld = 1'b0;
        cand     = '0;
        for (int i = PORTS; i >= 1; i--) begin
            cand = IDX_W'((int'(rr_last) + i) % PORTS);
            if (req[cand]) begin
                pick_idx = cand;
                pick_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/eth_tx_frame_arbiter.sv
// Frame-granular round-robin arbiter feeding one byte-wide AXI-Stream TX FIFO input.
module eth_tx_frame_arbiter
    import eth_tx_arb_pkg::*;
#(
    parameter int PORTS         = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int MAX_FRAME_LEN = 1522,
    parameter int CNT_W         = $clog2(MAX_FRAME_LEN + 1)
) (
    input  logic                          logic_clk,
    input  logic                          logic_rst_n,
    input  logic [PORTS*DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [PORTS-1:0]              s_axis_tvalid,
    output logic [PORTS-1:0]              s_axis_tready,
    input  logic [PORTS-1:0]              s_axis_tlast,
    input  logic [PORTS-1:0]              s_axis_tuser,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tuser,
    input  logic [PORTS-1:0]              port_enable,
    output logic [$clog2(PORTS)-1:0]      grant_idx,
    output logic                          busy,
    output logic [PORTS-1:0]              oversize
);

    localparam int IDX_W = idx_width(PORTS);

    arb_state_e             state_q, state_d;
    logic [IDX_W-1:0]       grant_q, grant_d;
    logic [IDX_W-1:0]       rr_last_q, rr_last_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [PORTS-1:0]       oversize_q, oversize_d;

    logic [PORTS-1:0]       req;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_vld;
    logic [PORTS-1:0]       grant_mask;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic                   sel_valid;
    logic                   sel_last;
    logic                   sel_user;
    logic                   at_limit;

    assign req        = s_axis_tvalid & port_enable;
    assign grant_mask = PORTS'(1) << grant_q;
    assign at_limit   = (cnt_q == CNT_W'(MAX_FRAME_LEN - 1));

    rr_pick #(
        .PORTS (PORTS),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req      (req),
        .rr_last  (rr_last_q),
        .pick_idx (pick_idx),
        .pick_vld (pick_vld)
    );

    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_user  = 1'b0;
        for (int p = 0; p < PORTS; p++) begin
            if (grant_q == IDX_W'(p)) begin
                sel_data  = s_axis_tdata[p*DATA_WIDTH +: DATA_WIDTH];
                sel_valid = s_axis_tvalid[p];
                sel_last  = s_axis_tlast[p];
                sel_user  = s_axis_tuser[p];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_last_d     = rr_last_q;
        cnt_d         = cnt_q;
        oversize_d    = '0;
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        s_axis_tready = '0;

        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_d   = pick_idx;
                    rr_last_d = pick_idx;
                    cnt_d     = '0;
                    state_d   = XFER;
                end
            end
            XFER: begin
                // The MAX_FRAME_LEN-th beat is forced to close the frame as bad unless it already ends it.
                m_axis_tdata  = sel_data;
                m_axis_tvalid = sel_valid;
                m_axis_tlast  = sel_last | at_limit;
                m_axis_tuser  = sel_user | (at_limit & ~sel_last);
                s_axis_tready = grant_mask & {PORTS{m_axis_tready}};
                if (sel_valid && m_axis_tready) begin
                    if (cnt_q != CNT_W'(MAX_FRAME_LEN)) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (sel_last) begin
                        state_d = IDLE;
                    end else if (at_limit) begin
                        state_d    = DROP;
                        oversize_d = grant_mask;
                    end
                end
            end
            DROP: begin
                s_axis_tready = grant_mask;
                if (sel_valid && sel_last) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge logic_clk) begin
        if (!logic_rst_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_last_q  <= IDX_W'(PORTS - 1);
            cnt_q      <= '0;
            oversize_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_last_q  <= rr_last_d;
            cnt_q      <= cnt_d;
            oversize_q <= oversize_d;
        end
    end

    assign grant_idx = grant_q;
    assign busy      = (state_q != IDLE);
    assign oversize  = oversize_q;

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Directed bench for eth_tx_frame_arbiter: cycle vector table plus frame-level sequences.
module tb_eth_tx_frame_arbiter;

    localparam int P  = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [P*DW-1:0] s_tdata;
    logic [P-1:0]    s_tvalid, s_tlast, s_tuser, en;
    logic            m_tready;

    logic [P-1:0]    a_srdy, b_srdy, a_ovs, b_ovs;
    logic [DW-1:0]   a_md, b_md;
    logic            a_mv, a_ml, a_mu, a_busy, b_mv, b_ml, b_mu, b_busy;
    logic [1:0]      a_gi, b_gi;

    always #5 clk = ~clk;

    eth_tx_frame_arbiter #(.PORTS(P), .DATA_WIDTH(DW)) dut_a (
        .logic_clk(clk), .logic_rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(a_srdy),
        .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(a_md), .m_axis_tvalid(a_mv), .m_axis_tready(m_tready),
        .m_axis_tlast(a_ml), .m_axis_tuser(a_mu),
        .port_enable(en), .grant_idx(a_gi), .busy(a_busy), .oversize(a_ovs)
    );

    eth_tx_frame_arbiter #(.PORTS(P), .DATA_WIDTH(DW), .MAX_FRAME_LEN(16)) dut_b (
        .logic_clk(clk), .logic_rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(b_srdy),
        .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(b_md), .m_axis_tvalid(b_mv), .m_axis_tready(m_tready),
        .m_axis_tlast(b_ml), .m_axis_tuser(b_mu),
        .port_enable(en), .grant_idx(b_gi), .busy(b_busy), .oversize(b_ovs)
    );

    typedef struct packed {
        logic [3:0] vld, lst, usr, en;
        logic       mrdy;
        logic [7:0] d;
        logic [7:0] md;
        logic       mv, ml, mu;
        logic [3:0] srdy;
        logic       busy;
        logic [1:0] gi;
    } vec_t;

    vec_t tbl[14];

    int total = 0;
    int bad   = 0;

    // Source model state
    int  len[P], pos[P], nfr[P];
    bit  use_b;
    int  rdy_mode;
    logic [9:0] lg[$];
    int  lg_cyc[$];
    int  ovs_n, ovs_cyc, mirror_err, cyc;
    logic [3:0] ovs_val;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic clear_src();
        for (int p = 0; p < P; p++) begin
            len[p] = 0; pos[p] = 0; nfr[p] = 0;
        end
        lg.delete(); lg_cyc.delete();
        ovs_n = 0; ovs_cyc = 0; ovs_val = '0; mirror_err = 0; cyc = 0;
        rdy_mode = 0; use_b = 1'b0; en = 4'b1111;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; s_tvalid = '0; s_tlast = '0; s_tuser = '0; s_tdata = '0; m_tready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_src(input int ncyc);
        logic mv, ml, mu, busy_s;
        logic [7:0] md;
        logic [3:0] srdy, ovs, exp_rdy;
        logic [1:0] gi;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            m_tready = (rdy_mode == 0) ? 1'b1 : ((c % 2) == 0);
            for (int p = 0; p < P; p++) begin
                s_tvalid[p] = (nfr[p] > 0);
                s_tlast[p]  = (pos[p] == len[p] - 1);
                s_tuser[p]  = 1'b0;
                s_tdata[p*DW +: DW] = 8'((p << 6) | (pos[p] & 63));
            end
            #4;
            mv = use_b ? b_mv : a_mv;   ml = use_b ? b_ml : a_ml;   mu = use_b ? b_mu : a_mu;
            md = use_b ? b_md : a_md;   srdy = use_b ? b_srdy : a_srdy;
            ovs = use_b ? b_ovs : a_ovs; busy_s = use_b ? b_busy : a_busy; gi = use_b ? b_gi : a_gi;
            if (mv && m_tready) begin
                lg.push_back({mu, ml, md});
                lg_cyc.push_back(cyc);
            end
            if (ovs != 0) begin
                ovs_n++; ovs_val = ovs; ovs_cyc = cyc;
            end
            exp_rdy = busy_s ? (4'(m_tready) << gi) : 4'b0000;
            if (rdy_mode == 1 && srdy != exp_rdy) mirror_err++;
            for (int p = 0; p < P; p++) begin
                if (s_tvalid[p] && srdy[p]) begin
                    pos[p]++;
                    if (pos[p] == len[p]) begin
                        pos[p] = 0;
                        nfr[p]--;
                    end
                end
            end
            cyc++;
        end
    endtask

    initial begin
        int errs, fport;
        logic [16:0] act17, exp17;

        tbl[0]  = '{4'b0100, 4'b0000, 4'b0000, 4'b1111, 1'b1, 8'd10, 8'd0,  1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
        tbl[1]  = '{4'b0100, 4'b0000, 4'b0000, 4'b1111, 1'b0, 8'd10, 8'd42, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd2};
        tbl[2]  = '{4'b0100, 4'b0000, 4'b0000, 4'b1111, 1'b1, 8'd10, 8'd42, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd2};
        tbl[3]  = '{4'b0100, 4'b0000, 4'b0000, 4'b1111, 1'b0, 8'd11, 8'd43, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd2};
        tbl[4]  = '{4'b0101, 4'b0000, 4'b0000, 4'b1111, 1'b1, 8'd11, 8'd43, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd2};
        tbl[5]  = '{4'b0101, 4'b0100, 4'b0000, 4'b1111, 1'b1, 8'd12, 8'd44, 1'b1, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd2};
        tbl[6]  = '{4'b0101, 4'b0000, 4'b0000, 4'b1111, 1'b1, 8'd13, 8'd0,  1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd2};
        tbl[7]  = '{4'b0101, 4'b0000, 4'b0001, 4'b1111, 1'b1, 8'd13, 8'd13, 1'b1, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[8]  = '{4'b0101, 4'b0001, 4'b0001, 4'b1111, 1'b1, 8'd14, 8'd14, 1'b1, 1'b1, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[9]  = '{4'b0101, 4'b0000, 4'b0000, 4'b1110, 1'b1, 8'd15, 8'd0,  1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
        tbl[10] = '{4'b0101, 4'b0000, 4'b0000, 4'b1110, 1'b1, 8'd15, 8'd47, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd2};
        tbl[11] = '{4'b0001, 4'b0000, 4'b0000, 4'b1110, 1'b1, 8'd16, 8'd48, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd2};
        tbl[12] = '{4'b0101, 4'b0100, 4'b0000, 4'b0000, 1'b1, 8'd17, 8'd49, 1'b1, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd2};
        tbl[13] = '{4'b0101, 4'b0000, 4'b0000, 4'b0000, 1'b1, 8'd18, 8'd0,  1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd2};

        clear_src();
        rst_n = 1'b0; s_tvalid = '0; s_tlast = '0; s_tuser = '0; s_tdata = '0; m_tready = 1'b1;
        repeat (3) @(negedge clk);
        #4;
        chk("reset_a", {a_mv, a_ml, a_mu, a_srdy, a_busy, a_gi, a_ovs}, 32'h0);
        chk("reset_b", {b_mv, b_ml, b_mu, b_srdy, b_busy, b_gi, b_ovs}, 32'h0);
        rst_n = 1'b1;

        // Cycle-accurate vector table on the default-length instance
        for (int r = 0; r < 14; r++) begin
            @(negedge clk);
            s_tvalid = tbl[r].vld; s_tlast = tbl[r].lst; s_tuser = tbl[r].usr;
            en = tbl[r].en; m_tready = tbl[r].mrdy;
            for (int p = 0; p < P; p++) s_tdata[p*DW +: DW] = tbl[r].d + 8'(p * 16);
            #4;
            exp17 = {tbl[r].busy ? tbl[r].md : 8'h00, tbl[r].mv, tbl[r].ml, tbl[r].mu,
                     tbl[r].srdy, tbl[r].busy, tbl[r].gi};
            act17 = {tbl[r].busy ? a_md : 8'h00, a_mv, a_ml, a_mu, a_srdy, a_busy, a_gi};
            chk($sformatf("vec%0d", r), 32'(act17), 32'(exp17));
        end

        // Single port, 64-beat frame
        do_reset(); clear_src();
        len[0] = 64; nfr[0] = 1;
        run_src(70);
        chk("single_count", lg.size(), 64);
        errs = 0;
        for (int i = 0; i < lg.size(); i++)
            if (lg[i] != {1'b0, (i == 63), 8'(i)}) errs++;
        chk("single_data", errs, 0);
        chk("single_latency", (lg.size() > 0) ? lg_cyc[0] : -1, 1);
        chk("single_grant", a_gi, 0);

        // Fairness: all ports offer two 10-beat frames
        do_reset(); clear_src();
        for (int p = 0; p < P; p++) begin len[p] = 10; nfr[p] = 2; end
        run_src(100);
        chk("fair_count", lg.size(), 80);
        errs = 0;
        for (int i = 0; i < lg.size(); i++)
            if (lg[i] != {1'b0, ((i % 10) == 9), 8'((((i / 10) % 4) << 6) | (i % 10))}) errs++;
        chk("fair_order", errs, 0);
        chk("fair_span", (lg.size() > 0) ? lg_cyc[lg.size()-1] - lg_cyc[0] : -1, 86);

        // Backpressure: downstream ready toggles
        do_reset(); clear_src();
        len[1] = 8; nfr[1] = 1; rdy_mode = 1;
        run_src(25);
        rdy_mode = 0;
        chk("bp_count", lg.size(), 8);
        errs = 0;
        for (int i = 0; i < lg.size(); i++)
            if (lg[i] != {1'b0, (i == 7), 8'((1 << 6) | i)}) errs++;
        chk("bp_data", errs, 0);
        chk("bp_ready_mirror", mirror_err, 0);

        // Oversize: 20-beat frame into MAX_FRAME_LEN=16, then port 1 frame
        do_reset(); clear_src();
        use_b = 1'b1;
        len[0] = 20; nfr[0] = 1; len[1] = 3; nfr[1] = 1;
        run_src(40);
        chk("ovs_count", lg.size(), 19);
        errs = 0;
        for (int i = 0; i < lg.size(); i++) begin
            if (i < 16) begin
                if (lg[i] != {(i == 15), (i == 15), 8'(i)}) errs++;
            end else if (lg[i] != {1'b0, (i == 18), 8'((1 << 6) | (i - 16))}) errs++;
        end
        chk("ovs_data", errs, 0);
        chk("ovs_pulses", ovs_n, 1);
        chk("ovs_port", ovs_val, 4'b0001);
        chk("ovs_timing", (lg.size() > 15) ? ovs_cyc - lg_cyc[15] : -1, 1);
        chk("ovs_drop_gap", (lg.size() > 16) ? lg_cyc[16] - lg_cyc[15] : -1, 6);

        // Exact-length frame: no truncation
        do_reset(); clear_src();
        use_b = 1'b1;
        len[2] = 16; nfr[2] = 1;
        run_src(22);
        chk("exact_count", lg.size(), 16);
        errs = 0;
        for (int i = 0; i < lg.size(); i++)
            if (lg[i] != {1'b0, (i == 15), 8'((2 << 6) | i)}) errs++;
        chk("exact_data", errs, 0);
        chk("exact_no_ovs", ovs_n, 0);

        // Port enable mask excludes port 1
        do_reset(); clear_src();
        en = 4'b1101;
        for (int p = 0; p < P; p++) begin len[p] = 4; nfr[p] = 2; end
        run_src(60);
        chk("en_count", lg.size(), 24);
        errs = 0; fport = 0;
        for (int i = 0; i < lg.size(); i++) begin
            if (lg[i][7:6] == 2'd1) fport++;
            if (lg[i][7:0] != 8'(((((i / 4) % 3) == 0 ? 0 : ((i / 4) % 3) + 1) << 6) | (i % 4))) errs++;
        end
        chk("en_port1_beats", fport, 0);
        chk("en_order", errs, 0);

        // Reset mid-frame, then port 0 wins first
        do_reset(); clear_src();
        len[3] = 30; nfr[3] = 1;
        run_src(5);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #4;
        chk("midrst_outputs", {a_mv, a_ml, a_mu, a_srdy, a_busy, a_gi, a_ovs}, 32'h0);
        s_tvalid = '0;
        rst_n = 1'b1;
        clear_src();
        len[0] = 4; nfr[0] = 1; len[3] = 4; nfr[3] = 1;
        run_src(14);
        chk("midrst_count", lg.size(), 8);
        chk("midrst_first_port", (lg.size() > 0) ? 32'(lg[0][7:6]) : 32'hFF, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
